// File: rtl/sfifo_pkg.sv
// Shared constants and width helpers for the flexible synchronous FIFO.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package sfifo_pkg;

  // Read-data presentation modes.
  localparam int FWFT_REG  = 0;  // rdata registered on an accepted read
  localparam int FWFT_FALL = 1;  // head entry always visible on rdata

  // Address bits needed to index DEPTH entries.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer/count width: address bits plus one wrap bit, so count can reach DEPTH.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sfifo_flex_if.sv
// Bundle of FIFO request, data and status signals.
// Latency: n/a (wiring only).
// Backpressure: the master must watch wfull/rempty; rejected requests are flagged.
interface sfifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import sfifo_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sfifo_flex_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one async read port.
// Latency: write visible to the read port the cycle after the write edge.
// Backpressure: none; the controller decides when writes are legal.
module sfifo_flex_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; stale contents are never exposed as valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo_flex.sv
// Synchronous FIFO with selectable registered or fall-through read and level flags.
// Latency: FWFT=0 read data 1 cycle after rinc; FWFT=1 written word visible 1 cycle after write.
// Backpressure: writes rejected when full (unless a read frees space that cycle), reads when empty; each pulses overflow/underflow.
module sfifo_flex
  import sfifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_REG
) (
  input  logic        clk,
  input  logic        rst,
  sfifo_flex_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] head_dat;
  logic             rd_acc, wr_acc;
  logic             full, empty;

  // Flags decode only the registered count, so they never glitch.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  sfifo_flex_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (head_dat)
  );

  // Request acceptance and next-state for pointers, count, pulses and read register.
  always_comb begin
    rd_acc  = bus.rinc & ~empty;
    // A full FIFO still takes a write when the same-cycle read frees a slot.
    wr_acc  = bus.winc & (~full | rd_acc);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    ovf_d   = bus.winc & ~wr_acc;
    udf_d   = bus.rinc & ~rd_acc;
    if (wr_acc) begin
      wptr_d = wptr_q + CW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + CW'(1);
      if (FWFT == FWFT_REG) begin
        rdata_d = head_dat;
      end
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rdata_q <= rdata_d;
    end
  end

  // In fall-through mode the head is shown directly; zero while empty keeps reset output clean.
  assign bus.rdata        = (FWFT == FWFT_FALL) ? (empty ? '0 : head_dat) : rdata_q;
  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
